// File: rtl/opo_lock_pkg.sv
// Shared types and constants for the lock-in reference path.
package opo_lock_pkg;

  localparam int PHASE_W    = 32;
  localparam int REF_W      = 16;
  localparam int LUT_ADDR_W = 10;
  localparam int LUT_W      = 15;

  localparam logic [PHASE_W-1:0] QUARTER = 32'h4000_0000;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
  typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_e;

  // Odd quadrants walk the quarter table backwards.
  function automatic logic is_mirrored(input quad_e q);
    return (q == Q1) || (q == Q3);
  endfunction

endpackage

// File: rtl/ref_nco_if.sv
// Config handshake and reference outputs of the lock-in NCO.
interface ref_nco_if
  import opo_lock_pkg::*;
#(
  parameter int OUT_W = REF_W
);
  logic [PHASE_W-1:0]      ftw_in;
  logic [PHASE_W-1:0]      phase_off_in;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [PHASE_W-1:0]      counter;
  logic [PHASE_W-1:0]      cnt_inc;
  logic signed [OUT_W-1:0] ref_sin;
  logic signed [OUT_W-1:0] ref_cos;
  logic                    ref_valid;
  logic                    wrap_pulse;

  modport master (
    output ftw_in, phase_off_in, cfg_valid,
    input  cfg_ready, counter, cnt_inc, ref_sin, ref_cos, ref_valid, wrap_pulse
  );

  modport slave (
    input  ftw_in, phase_off_in, cfg_valid,
    output cfg_ready, counter, cnt_inc, ref_sin, ref_cos, ref_valid, wrap_pulse
  );
endinterface

// File: rtl/ref_nco_quarter_lut.sv
// Dual-read registered quarter-wave sine ROM, L[i] = round(32767*sin(2pi(i+0.5)/(4*2^ADDR_W))).
module ref_nco_quarter_lut
  import opo_lock_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [LUT_W-1:0]  dat_a,
  output logic [LUT_W-1:0]  dat_b
);

  localparam int  DEPTH  = 1 << ADDR_W;
  localparam real TWO_PI = 6.283185307179586;

  logic [LUT_W-1:0] rom [DEPTH];

  // Half-sample offset keeps every entry in 1..32767, so negation is always safe.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = LUT_W'($rtoi(32767.0 * $sin(TWO_PI * (real'(i) + 0.5) / real'(4 * DEPTH)) + 0.5));
  end

  always_ff @(posedge clk) begin
    dat_a <= rom[addr_a];
    dat_b <= rom[addr_b];
  end

endmodule

// File: rtl/ref_nco.sv
// Reference NCO: phase accumulator with boundary-deferred retune and 3-stage sin/cos pipeline.
module ref_nco
  import opo_lock_pkg::*;
#(
  parameter int LUT_ADDR_W = opo_lock_pkg::LUT_ADDR_W,
  parameter int OUT_W      = REF_W
) (
  input  logic     clk,
  input  logic     rst,
  ref_nco_if.slave bus
);

  localparam int SHIFT = PHASE_W - 2 - LUT_ADDR_W;

  cfg_state_e state, state_nxt;
  logic [PHASE_W-1:0] acc, inc_active, off_active, ftw_pend, off_pend;
  logic [PHASE_W:0]   acc_sum;
  logic               carry, capture, apply;

  assign acc_sum = {1'b0, acc} + {1'b0, inc_active};
  assign carry   = acc_sum[PHASE_W];
  assign capture = bus.cfg_valid && (state == CFG_IDLE);

  // A zero tuning word never carries, so pending config applies straight away.
  always_comb begin
    state_nxt     = state;
    apply         = 1'b0;
    bus.cfg_ready = 1'b0;
    case (state)
      CFG_IDLE: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) state_nxt = CFG_PEND;
      end
      CFG_PEND: begin
        apply = carry || (inc_active == '0);
        if (apply) state_nxt = CFG_IDLE;
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CFG_IDLE;
      acc        <= '0;
      inc_active <= '0;
      off_active <= '0;
      ftw_pend   <= '0;
      off_pend   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_sum[PHASE_W-1:0];
      if (capture) begin
        ftw_pend <= bus.ftw_in;
        off_pend <= bus.phase_off_in;
      end
      if (apply) begin
        inc_active <= ftw_pend;
        off_active <= off_pend;
      end
    end
  end

  function automatic logic signed [OUT_W-1:0] signed_ref(input quad_e q, input logic [LUT_W-1:0] mag);
    logic signed [OUT_W-1:0] m;
    m = $signed({{(OUT_W - LUT_W){1'b0}}, mag});
    return ((q == Q2) || (q == Q3)) ? -m : m;
  endfunction

  // ---- S1: phase = accumulator + offset
  logic [PHASE_W-1:0]    ph_s1;
  logic                  unused_ph_lsb;
  logic [1:0]            quad_p1;
  logic [LUT_ADDR_W-1:0] addr_p1;
  logic [PHASE_W-1:0]    cnt_p1, inc_p1;
  logic                  wrap_p1, vld_p1;

  assign ph_s1         = acc + off_active;
  assign unused_ph_lsb = ^ph_s1[SHIFT-1:0];

  always_ff @(posedge clk) begin
    quad_p1 <= ph_s1[PHASE_W-1:PHASE_W-2];
    addr_p1 <= ph_s1[PHASE_W-3:SHIFT];
    cnt_p1  <= acc;
    inc_p1  <= inc_active;
    wrap_p1 <= carry;
  end

  // ---- S2: quadrant decode, mirrored addresses, registered table read
  quad_e                 q_sin_s2, q_cos_s2, q_sin_p2, q_cos_p2;
  logic [LUT_ADDR_W-1:0] addr_sin_s2, addr_cos_s2;
  logic [LUT_W-1:0]      mag_sin_p2, mag_cos_p2;
  logic [PHASE_W-1:0]    cnt_p2, inc_p2;
  logic                  wrap_p2, vld_p2;

  assign q_sin_s2    = quad_e'(quad_p1);
  assign q_cos_s2    = quad_e'(quad_p1 + QUARTER[PHASE_W-1:PHASE_W-2]);
  assign addr_sin_s2 = is_mirrored(q_sin_s2) ? ~addr_p1 : addr_p1;
  assign addr_cos_s2 = is_mirrored(q_cos_s2) ? ~addr_p1 : addr_p1;

  ref_nco_quarter_lut #(.ADDR_W(LUT_ADDR_W)) u_lut (
    .clk    (clk),
    .addr_a (addr_sin_s2),
    .addr_b (addr_cos_s2),
    .dat_a  (mag_sin_p2),
    .dat_b  (mag_cos_p2)
  );

  always_ff @(posedge clk) begin
    q_sin_p2 <= q_sin_s2;
    q_cos_p2 <= q_cos_s2;
    cnt_p2   <= cnt_p1;
    inc_p2   <= inc_p1;
    wrap_p2  <= wrap_p1;
  end

  // ---- S3: sign restore and output register; data holds until the pipe has filled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1         <= 1'b0;
      vld_p2         <= 1'b0;
      bus.ref_valid  <= 1'b0;
      bus.wrap_pulse <= 1'b0;
      bus.counter    <= '0;
      bus.cnt_inc    <= '0;
      bus.ref_sin    <= '0;
      bus.ref_cos    <= '0;
    end else begin
      vld_p1         <= 1'b1;
      vld_p2         <= vld_p1;
      bus.ref_valid  <= vld_p2;
      bus.wrap_pulse <= vld_p2 && wrap_p2;
      if (vld_p2) begin
        bus.counter <= cnt_p2;
        bus.cnt_inc <= inc_p2;
        bus.ref_sin <= signed_ref(q_sin_p2, mag_sin_p2);
        bus.ref_cos <= signed_ref(q_cos_p2, mag_cos_p2);
      end
    end
  end

endmodule

// File: tb/tb_ref_nco.sv
// Self-checking bench for ref_nco against a sample-level behavioural NCO model.
module tb_ref_nco;
  import opo_lock_pkg::*;

  localparam int  A   = 10;
  localparam real PI2 = 6.283185307179586;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ref_nco_if #(.OUT_W(16)) bus ();
  ref_nco #(.LUT_ADDR_W(A), .OUT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] inc;
    int          s;
    int          c;
    bit          wrap;
  } samp_t;

  logic [31:0] m_acc, m_inc, m_off, m_pftw, m_poff;
  bit          m_pend, m_valid;
  samp_t       hist[$];
  samp_t       cur;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          l1023, l0;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Ideal reference: full-circle index k = top A+2 phase bits, sampled at bin centre.
  function automatic samp_t make_samp(input logic [31:0] cnt, input logic [31:0] inc,
                                      input logic [31:0] p, input bit wrap);
    samp_t s;
    int    k;
    real   th;
    k      = int'(p >> (32 - (A + 2)));
    th     = PI2 * (real'(k) + 0.5) / real'(1 << (A + 2));
    s.cnt  = cnt;
    s.inc  = inc;
    s.s    = rnd(32767.0 * $sin(th));
    s.c    = rnd(32767.0 * $cos(th));
    s.wrap = wrap;
    return s;
  endfunction

  function automatic bit carry_next();
    logic [32:0] s;
    s = {1'b0, m_acc} + {1'b0, m_inc};
    return s[32];
  endfunction

  task automatic model_reset();
    m_acc = '0; m_inc = '0; m_off = '0; m_pftw = '0; m_poff = '0;
    m_pend = 1'b0; m_valid = 1'b0;
    hist.delete();
    cur = '{cnt: '0, inc: '0, s: 0, c: 0, wrap: 1'b0};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    tests++;
    assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d(+-%0d)", tag, cyc, obs, exp, tol);
    end
  endtask

  task automatic check_outputs();
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_pend));
    chk("ref_valid", 32'(bus.ref_valid), 32'(m_valid));
    chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(cur.wrap));
    chk("counter", bus.counter, cur.cnt);
    chk("cnt_inc", bus.cnt_inc, cur.inc);
    chk_near("ref_sin", int'(bus.ref_sin), cur.s, 1);
    chk_near("ref_cos", int'(bus.ref_cos), cur.c, 1);
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic tick();
    logic [32:0] sum;
    bit          cap;
    @(posedge clk);
    if (rst) begin
      sum = {1'b0, m_acc} + {1'b0, m_inc};
      hist.push_back(make_samp(m_acc, m_inc, m_acc + m_off, sum[32]));
      cap = bus.cfg_valid && !m_pend;
      if (m_pend && (sum[32] || m_inc == 0)) begin
        m_inc  = m_pftw;
        m_off  = m_poff;
        m_pend = 1'b0;
      end
      if (cap) begin
        m_pftw = bus.ftw_in;
        m_poff = bus.phase_off_in;
        m_pend = 1'b1;
      end
      m_acc = sum[31:0];
      if (hist.size() == 3) begin
        cur     = hist.pop_front();
        m_valid = 1'b1;
      end
    end
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(n < 400), 32'd1);
  endtask

  task automatic send(input logic [31:0] f, input logic [31:0] o);
    wait_ready();
    bus.ftw_in       = f;
    bus.phase_off_in = o;
    bus.cfg_valid    = 1'b1;
    tick();
    bus.cfg_valid    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hits, last_wrap;
    l1023 = rnd(32767.0 * $sin(PI2 * 1023.5 / 4096.0));
    l0    = rnd(32767.0 * $sin(PI2 * 0.5 / 4096.0));
    bus.ftw_in = '0; bus.phase_off_in = '0; bus.cfg_valid = 1'b0;
    model_reset();

    // Reset held, then idle with zero tuning word
    repeat (5) tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) tick();

    // Basic tone 2^26 from idle
    send(32'h0400_0000, 32'h0);
    repeat (8) tick();
    hits = 0;
    last_wrap = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.wrap_pulse === 1'b1) begin
        if (last_wrap >= 0) chk("wrap_period", 32'(cyc - last_wrap), 32'd64);
        last_wrap = cyc;
      end
      if (bus.ref_valid === 1'b1 && bus.counter === 32'h4000_0000) begin
        hits++;
        chk("sin_at_quarter", 32'(int'(bus.ref_sin)), 32'(l1023));
        chk_near("cos_at_quarter", int'(bus.ref_cos), 0, l0);
      end
    end
    chk("quarter_seen", 32'(hits > 0), 32'd1);

    // Quadrature offset 2^30
    send(32'h0400_0000, 32'h4000_0000);
    wait_ready();
    repeat (80) tick();

    // Mid-period retune to 2^27
    n = 0;
    while (m_acc[31:30] != 2'b10 && n < 100) begin tick(); n++; end
    chk("mid_period_wait", 32'(n < 100), 32'd1);
    send(32'h0800_0000, 32'h0);
    wait_ready();
    repeat (60) tick();

    // Config handed in on the carry cycle waits a full period
    send(32'h0400_0000, 32'h0);
    wait_ready();
    repeat (5) tick();
    n = 0;
    while (!carry_next() && n < 200) begin tick(); n++; end
    chk("carry_wait", 32'(n < 200), 32'd1);
    bus.ftw_in = 32'h0200_0000; bus.phase_off_in = 32'h1234_5678; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 200) begin tick(); n++; end
    chk("simul_apply_delay", 32'(n), 32'd64);
    repeat (20) tick();

    // Randomized retunes, including zero tuning words
    for (int i = 0; i < 400; i++) begin
      bus.cfg_valid    = ($urandom_range(0, 3) == 0);
      bus.ftw_in       = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom() | 32'h0100_0000);
      bus.phase_off_in = $urandom();
      tick();
    end
    bus.cfg_valid = 1'b0;

    // Reset while a config is pending
    send(32'h0010_0000, 32'h0);
    wait_ready();
    send(32'h0100_0000, 32'h0000_0123);
    repeat (3) tick();
    chk("pending_before_reset", 32'(bus.cfg_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) tick();
    chk("pending_lost", bus.cnt_inc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
